// File: rtl/el2_pkg.sv
// Shared types for the decode-stage trace capture path.
package el2_pkg;

  // One captured retirement/exception/interrupt record.
  typedef struct packed {
    logic [31:1] pc;
    logic [31:0] insn;
    logic        exception;
    logic        interrupt;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic        lost;
  } el2_trace_rec_t;

endpackage

// File: rtl/el2_trace_rec_fifo.sv
// Generic DEPTH-entry synchronous FIFO of type T; occupancy tracked by a level counter.
module el2_trace_rec_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop_en;
  logic          push_en;

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_en  = pop & (level != '0);
  assign push_en = push & ((level != LW'(DEPTH)) | pop_en);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_en) rd_ptr <= rd_ptr + PW'(1);
      case ({push_en, pop_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/el2_dec_trace_fifo.sv
// Trace capture of wb1 retire/exception/interrupt records into a drop-on-full FIFO
// drained over a valid/ready trace port.
module el2_dec_trace_fifo
  import el2_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    dec_tlu_trace_disable,
  input  logic                    dec_tlu_i0_valid_wb1,
  input  logic                    dec_tlu_i0_exc_valid_wb1,
  input  logic                    dec_tlu_int_valid_wb1,
  input  logic [4:0]              dec_tlu_exc_cause_wb1,
  input  logic [31:0]             dec_tlu_mtval_wb1,
  input  logic [31:1]             dec_tlu_pc_wb1,
  input  logic [31:0]             dec_tlu_insn_wb1,
  input  logic                    trace_ready,
  input  logic                    trace_ovf_clr,
  output logic                    trace_valid,
  output logic [31:1]             trace_pc,
  output logic [31:0]             trace_insn,
  output logic                    trace_exception,
  output logic                    trace_interrupt,
  output logic [4:0]              trace_ecause,
  output logic [31:0]             trace_tval,
  output logic                    trace_lost,
  output logic                    trace_ovf,
  output logic [CNTW-1:0]         trace_drop_cnt,
  output logic [$clog2(DEPTH):0]  trace_level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  el2_trace_rec_t rec;
  el2_trace_rec_t head;
  logic           ev;
  logic           pop;
  logic           full;
  logic           push;
  logic           drop;
  logic           lost_pending;

  assign ev   = ~dec_tlu_trace_disable &
                (dec_tlu_i0_valid_wb1 | dec_tlu_i0_exc_valid_wb1 | dec_tlu_int_valid_wb1);
  assign pop  = trace_valid & trace_ready;
  assign full = (trace_level == LW'(DEPTH));
  assign push = ev & (~full | pop);
  assign drop = ev & full & ~pop;

  always_comb begin
    rec           = '0;
    rec.pc        = dec_tlu_pc_wb1;
    rec.insn      = dec_tlu_insn_wb1;
    rec.exception = dec_tlu_i0_exc_valid_wb1;
    rec.interrupt = dec_tlu_int_valid_wb1;
    rec.ecause    = dec_tlu_exc_cause_wb1;
    rec.tval      = dec_tlu_mtval_wb1;
    rec.lost      = lost_pending;
  end

  el2_trace_rec_fifo #(
    .DEPTH (DEPTH),
    .T     (el2_trace_rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .push      (push),
    .push_data (rec),
    .pop       (pop),
    .head      (head),
    .level     (trace_level)
  );

  // Drop bookkeeping; a drop in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lost_pending   <= 1'b0;
      trace_ovf      <= 1'b0;
      trace_drop_cnt <= '0;
    end else begin
      if (drop) begin
        lost_pending <= 1'b1;
        trace_ovf    <= 1'b1;
        if (trace_ovf_clr)        trace_drop_cnt <= CNTW'(1);
        else if (!(&trace_drop_cnt)) trace_drop_cnt <= trace_drop_cnt + CNTW'(1);
      end else begin
        if (push | trace_ovf_clr) lost_pending <= 1'b0;
        if (trace_ovf_clr) begin
          trace_ovf      <= 1'b0;
          trace_drop_cnt <= '0;
        end
      end
    end
  end

  assign trace_valid     = (trace_level != '0);
  assign trace_pc        = head.pc;
  assign trace_insn      = head.insn;
  assign trace_exception = head.exception;
  assign trace_interrupt = head.interrupt;
  assign trace_ecause    = head.ecause;
  assign trace_tval      = head.tval;
  assign trace_lost      = head.lost;

endmodule

// File: doc/el2_dec_trace_fifo.md
Name: el2_dec_trace_fifo

Overview:
Downstream consumer of the TLU writeback-1 retirement/exception/interrupt outputs. Captures one trace record per retired instruction, exception or interrupt, and buffers records in a small FIFO. Drains them to an external trace port over a valid/ready handshake, so a stalled trace sink never back-pressures the core. Dropped records are counted and flagged, never stalled.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
CNTW, 8, width of dropped-record counter

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
dec_tlu_trace_disable  in  1  MFDC trace disable; when 1, no new records captured
dec_tlu_i0_valid_wb1  in  1  instruction retired at wb1
dec_tlu_i0_exc_valid_wb1  in  1  exception at wb1
dec_tlu_int_valid_wb1  in  1  interrupt at wb1
dec_tlu_exc_cause_wb1  in  5  exception/interrupt cause
dec_tlu_mtval_wb1  in  32  mtval value
dec_tlu_pc_wb1  in  31  pc[31:1] of wb1 record
dec_tlu_insn_wb1  in  32  instruction word at wb1
trace_ready  in  1  sink accepts head record
trace_ovf_clr  in  1  clear drop counter and sticky overflow
trace_valid  out  1  head record valid
trace_pc  out  31  head pc[31:1]
trace_insn  out  32  head instruction
trace_exception  out  1  head is exception
trace_interrupt  out  1  head is interrupt
trace_ecause  out  5  head cause
trace_tval  out  32  head mtval
trace_lost  out  1  one or more records dropped immediately before head
trace_ovf  out  1  sticky overflow
trace_drop_cnt  out  CNTW  saturating dropped-record count
trace_level  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset: all outputs 0, read/write pointers 0, lost_pending 0.
- Capture event ev = ~trace_disable & (i0_valid | exc_valid | int_valid). Events with none set are ignored. Record holds all wb1 fields; exception/interrupt bits copied directly.
- Pop = trace_valid & trace_ready. Head fields are stable while trace_valid & ~trace_ready. Fields are registered storage; no combinational input->output path.
- Latency: event at cycle N into empty FIFO -> trace_valid=1 at N+1.
- Push accepted if level<DEPTH, or level==DEPTH with a pop in the same cycle. Simultaneous push and pop leaves level unchanged.
- Full with no pop: the record is dropped. trace_ovf is set. trace_drop_cnt increments and saturates at all-ones. lost_pending is set.
- The next accepted record stores lost=1, and lost_pending clears in that cycle. trace_lost reflects the head entry's stored lost bit.
- trace_ovf_clr: clears trace_drop_cnt, trace_ovf and lost_pending next cycle. If a drop happens in the same cycle, the drop wins: cnt=1, ovf=1, lost_pending=1.
- trace_disable asserting does not flush: queued entries keep draining. Deasserting resumes capture next event.
- Pointers are $clog2(DEPTH) bits, wrap modulo DEPTH. The full/empty distinction comes from the level counter.
- Reset mid-operation: all state clears immediately (async). Pending records are lost and not counted.

Decomposition:
- Shared package el2_pkg gets typedef el2_trace_rec_t: pc[31:1], insn, exception, interrupt, ecause, tval, lost.
- One natural sub-module: el2_trace_rec_fifo, a generic DEPTH-entry, parameterised-type synchronous FIFO with push/pop/level. el2_dec_trace_fifo adds capture, drop/lost/overflow logic.

Test Plan:
1. Single retire, pc=0x1000>>1, insn=0x00000013, ready=1 -> trace_valid=1 exactly one cycle later with identical fields; level returns to 0.
2. ready=0, 6 consecutive retires, DEPTH=4 -> level=4, drop_cnt=2, ovf=1. Then ready=1 and one more retire -> 4 originals drain in order, then the 5th-accepted record with trace_lost=1.
3. Full FIFO, push and pop same cycle -> no drop, level stays 4, drop_cnt unchanged.
4. Exception with cause=5'd2, mtval=0xDEADBEEF, no i0_valid -> record with exception=1, interrupt=0, ecause=2, tval=0xDEADBEEF.
5. trace_disable=1 with 2 queued entries and 3 new events -> 2 drain, nothing captured, drop_cnt unchanged; after disable=0 the next event is captured.
6. 300 drops with CNTW=8 -> drop_cnt=255 saturated. trace_ovf_clr simultaneous with a drop -> cnt=1, ovf=1. rst_l pulsed low mid-drain -> trace_valid=0 and level=0 asynchronously.
